// File: rtl/ddr3_rd_return.sv
// rtl/ddr3_rd_return.sv - DDR3 read return path: tag queue, burst capture FIFO, user beat handshake
//
// Receives the latency-aligned command word from the command delay line and queues
// the read tag. It captures BURST_BEATS PHY beats per read into a data FIFO and
// returns them to the user with a valid/ready handshake, the burst tag and a
// last-beat marker.
//
// Optional feature macro: DDR3_RD_TIMEOUT_EN (adds TIMEOUT_CYC and err_timeout).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   dly_cmd         delayed command word {valid, read, tag[5:0], addr[27:0]}
//   phy_rdata       PHY read data beat
//   phy_rvalid      phy_rdata valid this cycle
//   rd_valid        output beat available (data FIFO not empty)
//   rd_ready        consumer accepts beat
//   rd_data         output beat
//   rd_tag          tag of the burst the output beat belongs to
//   rd_last         final beat of the burst
//   pend_cnt        tags accepted whose bursts are not yet fully received
//   err_tag_ovf     sticky: tag pushed while tag FIFO full
//   err_orphan      sticky: beat received with no pending tag
//   err_data_ovf    sticky: beat received while data FIFO full
//   err_timeout     sticky: read data did not arrive in time (DDR3_RD_TIMEOUT_EN only)
module ddr3_rd_return #(
    parameter int DATA_W      = 64,
    parameter int BURST_BEATS = 8,
    parameter int TAG_DEPTH   = 8,
    parameter int DATA_DEPTH  = 32
`ifdef DDR3_RD_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [35:0]                    dly_cmd,
    input  logic [DATA_W-1:0]              phy_rdata,
    input  logic                           phy_rvalid,
    output logic                           rd_valid,
    input  logic                           rd_ready,
    output logic [DATA_W-1:0]              rd_data,
    output logic [5:0]                     rd_tag,
    output logic                           rd_last,
    output logic [$clog2(TAG_DEPTH):0]     pend_cnt,
    output logic                           err_tag_ovf,
    output logic                           err_orphan,
    output logic                           err_data_ovf
`ifdef DDR3_RD_TIMEOUT_EN
    ,
    output logic                           err_timeout
`endif
);

    localparam int TAW = $clog2(TAG_DEPTH);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int BW  = $clog2(BURST_BEATS);
    localparam int PW  = TAW + 1;

    // Tag FIFO
    logic [5:0]     tag_mem [TAG_DEPTH];
    logic [TAW:0]   tag_wptr;
    logic [TAW:0]   tag_rptr;
    logic           tag_empty;
    logic           tag_full;

    // Data FIFO
    logic [DATA_W-1:0] data_mem [DATA_DEPTH];
    logic [DAW:0]      data_wptr;
    logic [DAW:0]      data_rptr;
    logic              data_empty;
    logic              data_full;

    logic [BW-1:0]  in_cnt;
    logic [BW-1:0]  out_cnt;

    logic           tag_req;
    logic           tag_push;
    logic           tag_pop;
    logic           orphan;
    logic           beat_acc;
    logic           burst_done;
    logic           data_wr;
    logic           xfer;
    logic           out_last;

    // Address bits of the command word play no part in read return.
    logic           unused_addr;
    assign unused_addr = ^dly_cmd[27:0];

    always_comb begin
        tag_empty  = (tag_wptr == tag_rptr);
        tag_full   = (tag_wptr[TAW] != tag_rptr[TAW]) &&
                     (tag_wptr[TAW-1:0] == tag_rptr[TAW-1:0]);
        data_empty = (data_wptr == data_rptr);
        data_full  = (data_wptr[DAW] != data_rptr[DAW]) &&
                     (data_wptr[DAW-1:0] == data_rptr[DAW-1:0]);

        tag_req    = dly_cmd[35] & dly_cmd[34];
        tag_push   = tag_req && !tag_full;

        // Only an accepted push makes a burst pending; a dropped tag must not
        // let the following beats advance framing against a zero pend_cnt.
        orphan     = phy_rvalid && (pend_cnt == '0) && !tag_push;
        beat_acc   = phy_rvalid && !orphan;
        // Beats dropped for a full data FIFO still count toward burst framing.
        burst_done = beat_acc && (in_cnt == BW'(BURST_BEATS - 1));
        data_wr    = beat_acc && !data_full;

        rd_valid   = !data_empty;
        xfer       = rd_valid && rd_ready;
        out_last   = (out_cnt == BW'(BURST_BEATS - 1));
        tag_pop    = xfer && out_last && !tag_empty;

        // Gated so the outputs read as zero when there is nothing to present.
        rd_data    = rd_valid ? data_mem[data_rptr[DAW-1:0]] : '0;
        rd_tag     = tag_empty ? 6'd0 : tag_mem[tag_rptr[TAW-1:0]];
        rd_last    = rd_valid && out_last;
    end

    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_mem[tag_wptr[TAW-1:0]] <= dly_cmd[33:28];
        end
        if (data_wr) begin
            data_mem[data_wptr[DAW-1:0]] <= phy_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_wptr     <= '0;
            tag_rptr     <= '0;
            data_wptr    <= '0;
            data_rptr    <= '0;
            in_cnt       <= '0;
            out_cnt      <= '0;
            pend_cnt     <= '0;
            err_tag_ovf  <= 1'b0;
            err_orphan   <= 1'b0;
            err_data_ovf <= 1'b0;
        end else begin
            if (tag_push) begin
                tag_wptr <= tag_wptr + (TAW+1)'(1);
            end
            if (tag_pop) begin
                tag_rptr <= tag_rptr + (TAW+1)'(1);
            end
            if (data_wr) begin
                data_wptr <= data_wptr + (DAW+1)'(1);
            end
            if (xfer) begin
                data_rptr <= data_rptr + (DAW+1)'(1);
                out_cnt   <= out_cnt + BW'(1);
            end
            if (beat_acc) begin
                in_cnt <= in_cnt + BW'(1);
            end

            case ({tag_push, burst_done})
                2'b10:   pend_cnt <= pend_cnt + PW'(1);
                2'b01:   pend_cnt <= pend_cnt - PW'(1);
                default: pend_cnt <= pend_cnt;
            endcase

            if (tag_req && tag_full) begin
                err_tag_ovf <= 1'b1;
            end
            if (orphan) begin
                err_orphan <= 1'b1;
            end
            if (beat_acc && data_full) begin
                err_data_ovf <= 1'b1;
            end
        end
    end

`ifdef DDR3_RD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    // Counts idle cycles while reads are outstanding; saturates at TIMEOUT_CYC.
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (phy_rvalid || (pend_cnt == '0)) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TW'(TIMEOUT_CYC)) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
            if (tmo_cnt == TW'(TIMEOUT_CYC)) begin
                err_timeout <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ddr3_rd_return.sv
// tb/tb_ddr3_rd_return.sv - directed self-checking bench for ddr3_rd_return
module tb_ddr3_rd_return;

    logic        clk;
    logic        rst;
    logic [35:0] dly_cmd;
    logic [63:0] phy_rdata;
    logic        phy_rvalid;
    logic        rd_valid;
    logic        rd_ready;
    logic [63:0] rd_data;
    logic [5:0]  rd_tag;
    logic        rd_last;
    logic [3:0]  pend_cnt;
    logic        err_tag_ovf;
    logic        err_orphan;
    logic        err_data_ovf;
`ifdef DDR3_RD_TIMEOUT_EN
    logic        err_timeout;
`endif

    int checks;
    int failures;

    ddr3_rd_return dut (
        .clk          (clk),
        .rst          (rst),
        .dly_cmd      (dly_cmd),
        .phy_rdata    (phy_rdata),
        .phy_rvalid   (phy_rvalid),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_tag       (rd_tag),
        .rd_last      (rd_last),
        .pend_cnt     (pend_cnt),
        .err_tag_ovf  (err_tag_ovf),
        .err_orphan   (err_orphan),
        .err_data_ovf (err_data_ovf)
`ifdef DDR3_RD_TIMEOUT_EN
        ,
        .err_timeout  (err_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] rd_cmd(input logic [5:0] tag);
        return {1'b1, 1'b1, tag, 28'h0};
    endfunction

    task automatic do_reset();
        rst        = 1'b1;
        dly_cmd    = '0;
        phy_rvalid = 1'b0;
        phy_rdata  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_no_errs(input string tag);
        chk({tag, "_tag_ovf"},  64'(err_tag_ovf),  64'h0);
        chk({tag, "_orphan"},   64'(err_orphan),   64'h0);
        chk({tag, "_data_ovf"}, 64'(err_data_ovf), 64'h0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rd_ready   = 1'b0;
        do_reset();

        // Reset state
        chk("rst_valid", 64'(rd_valid), 64'h0);
        chk("rst_last",  64'(rd_last),  64'h0);
        chk("rst_data",  rd_data,       64'h0);
        chk("rst_tag",   64'(rd_tag),   64'h0);
        chk("rst_pend",  64'(pend_cnt), 64'h0);
        chk_no_errs("rst");

        // Basic burst: command aligned with first beat, consumer always ready
        rd_ready   = 1'b1;
        dly_cmd    = rd_cmd(6'h15);
        phy_rvalid = 1'b1;
        phy_rdata  = 64'h100;
        tick();
        dly_cmd = '0;
        chk("basic_valid0", 64'(rd_valid), 64'h1);
        chk("basic_data0",  rd_data,       64'h100);
        chk("basic_tag0",   64'(rd_tag),   64'h15);
        chk("basic_last0",  64'(rd_last),  64'h0);
        chk("basic_pend0",  64'(pend_cnt), 64'h1);
        for (int i = 1; i < 8; i++) begin
            phy_rdata = 64'h100 + 64'(i);
            tick();
            chk("basic_data", rd_data,       64'h100 + 64'(i));
            chk("basic_tag",  64'(rd_tag),   64'h15);
            chk("basic_last", 64'(rd_last),  (i == 7) ? 64'h1 : 64'h0);
            chk("basic_pend", 64'(pend_cnt), (i == 7) ? 64'h0 : 64'h1);
        end
        phy_rvalid = 1'b0;
        tick();
        chk("basic_drained", 64'(rd_valid), 64'h0);

        // Back-to-back bursts, second tag arrives with beat 8
        for (int i = 0; i < 16; i++) begin
            dly_cmd    = (i == 0) ? rd_cmd(6'h01) : (i == 8) ? rd_cmd(6'h02) : 36'h0;
            phy_rvalid = 1'b1;
            phy_rdata  = 64'h200 + 64'(i);
            tick();
            chk("b2b_data", rd_data,       64'h200 + 64'(i));
            chk("b2b_tag",  64'(rd_tag),   (i < 8) ? 64'h01 : 64'h02);
            chk("b2b_last", 64'(rd_last),  (i % 8 == 7) ? 64'h1 : 64'h0);
            chk("b2b_pend", 64'(pend_cnt), (i % 8 == 7) ? 64'h0 : 64'h1);
        end
        dly_cmd    = '0;
        phy_rvalid = 1'b0;
        tick();
        chk("b2b_drained", 64'(rd_valid), 64'h0);

        // Backpressure: 20 cycles stalled across two bursts
        rd_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            dly_cmd    = (c == 0) ? rd_cmd(6'h03) : (c == 8) ? rd_cmd(6'h04) : 36'h0;
            phy_rvalid = (c < 16);
            phy_rdata  = 64'h300 + 64'(c);
            tick();
            chk("bp_hold_valid", 64'(rd_valid), 64'h1);
            chk("bp_hold_data",  rd_data,       64'h300);
            chk("bp_hold_tag",   64'(rd_tag),   64'h03);
            chk("bp_hold_last",  64'(rd_last),  64'h0);
        end
        dly_cmd    = '0;
        phy_rvalid = 1'b0;
        chk("bp_pend", 64'(pend_cnt), 64'h0);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("bp_drain_valid", 64'(rd_valid), 64'h1);
            chk("bp_drain_data",  rd_data,       64'h300 + 64'(i));
            chk("bp_drain_tag",   64'(rd_tag),   (i < 8) ? 64'h03 : 64'h04);
            chk("bp_drain_last",  64'(rd_last),  (i % 8 == 7) ? 64'h1 : 64'h0);
            tick();
        end
        chk("bp_empty", 64'(rd_valid), 64'h0);
        chk_no_errs("bp");

        // Orphan beat
        phy_rvalid = 1'b1;
        phy_rdata  = 64'hDEAD;
        tick();
        phy_rvalid = 1'b0;
        chk("orphan_flag",  64'(err_orphan), 64'h1);
        chk("orphan_valid", 64'(rd_valid),   64'h0);
        tick();
        chk("orphan_valid2", 64'(rd_valid),  64'h0);
        chk("orphan_sticky", 64'(err_orphan), 64'h1);

        // Tag FIFO overflow: 9 commands, no data
        do_reset();
        rd_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            dly_cmd = rd_cmd(6'h20 + 6'(i));
            tick();
            if (i == 7) begin
                chk("tovf_pend8",   64'(pend_cnt),    64'h8);
                chk("tovf_not_yet", 64'(err_tag_ovf), 64'h0);
            end
        end
        dly_cmd = '0;
        chk("tovf_flag", 64'(err_tag_ovf), 64'h1);
        chk("tovf_pend", 64'(pend_cnt),    64'h8);

        // Data FIFO overflow: 5 bursts stalled, first 32 beats kept
        do_reset();
        rd_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            dly_cmd    = (i % 8 == 0) ? rd_cmd(6'h30 + 6'(i / 8)) : 36'h0;
            phy_rvalid = 1'b1;
            phy_rdata  = 64'h400 + 64'(i);
            tick();
            if (i == 31) chk("dovf_not_yet", 64'(err_data_ovf), 64'h0);
            if (i == 32) chk("dovf_flag",    64'(err_data_ovf), 64'h1);
        end
        dly_cmd    = '0;
        phy_rvalid = 1'b0;
        chk("dovf_pend", 64'(pend_cnt), 64'h0);
        rd_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk("dovf_data", rd_data,      64'h400 + 64'(i));
            chk("dovf_tag",  64'(rd_tag),  64'h30 + 64'(i / 8));
            chk("dovf_last", 64'(rd_last), (i % 8 == 7) ? 64'h1 : 64'h0);
            tick();
        end
        chk("dovf_empty",  64'(rd_valid),     64'h0);
        chk("dovf_sticky", 64'(err_data_ovf), 64'h1);

        // Reset mid-burst after 3 of 8 beats
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dly_cmd    = (i == 0) ? rd_cmd(6'h3A) : 36'h0;
            phy_rvalid = 1'b1;
            phy_rdata  = 64'h500 + 64'(i);
            tick();
        end
        dly_cmd    = '0;
        phy_rvalid = 1'b0;
        chk("mid_pend_pre",  64'(pend_cnt), 64'h1);
        chk("mid_valid_pre", 64'(rd_valid), 64'h1);
        do_reset();
        chk("mid_valid", 64'(rd_valid), 64'h0);
        chk("mid_pend",  64'(pend_cnt), 64'h0);
        chk_no_errs("mid");
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dly_cmd    = (i == 0) ? rd_cmd(6'h2B) : 36'h0;
            phy_rvalid = 1'b1;
            phy_rdata  = 64'h600 + 64'(i);
            tick();
            chk("fresh_data", rd_data,      64'h600 + 64'(i));
            chk("fresh_tag",  64'(rd_tag),  64'h2B);
            chk("fresh_last", 64'(rd_last), (i == 7) ? 64'h1 : 64'h0);
        end
        dly_cmd    = '0;
        phy_rvalid = 1'b0;
        tick();
        chk("fresh_empty", 64'(rd_valid), 64'h0);
        chk("fresh_pend",  64'(pend_cnt), 64'h0);
        chk_no_errs("fresh");

`ifdef DDR3_RD_TIMEOUT_EN
        // Timeout: tag pushed, no data
        do_reset();
        dly_cmd = rd_cmd(6'h11);
        tick();
        dly_cmd = '0;
        for (int i = 0; i < 63; i++) tick();
        chk("tmo_not_yet", 64'(err_timeout), 64'h0);
        tick();
        tick();
        chk("tmo_flag", 64'(err_timeout), 64'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddr3_rd_return.md
Name: ddr3_rd_return

Overview:
- Downstream consumer of the 36-bit command delay line (ddr3_sr36, PIPE_LEN set to read latency) in the DDR3 controller read path.
- Takes the delayed command word, which arrives aligned to the start of PHY read data, and queues the read tag.
- Captures BURST_BEATS data beats per read from the PHY and buffers them in a FIFO.
- Returns the beats to the user port with valid/ready handshake, tag and last-beat marker.

Parameters:
- DATA_W, 64, width of one PHY read data beat.
- BURST_BEATS, 8, beats per read burst (power of 2, 2..16).
- TAG_DEPTH, 8, tag FIFO entries (power of 2).
- DATA_DEPTH, 32, data FIFO entries (power of 2, ≥ BURST_BEATS).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- dly_cmd  in  36  delayed command word: [35] valid, [34] read, [33:28] tag, [27:0] address (ignored).
- phy_rdata  in  DATA_W  read data beat from PHY.
- phy_rvalid  in  1  phy_rdata valid this cycle.
- rd_valid  out  1  output beat available.
- rd_ready  in  1  consumer accepts beat.
- rd_data  out  DATA_W  output beat.
- rd_tag  out  6  tag of the burst the beat belongs to.
- rd_last  out  1  final beat of burst.
- pend_cnt  out  $clog2(TAG_DEPTH)+1  tags pushed whose bursts are not yet fully received.
- err_tag_ovf  out  1  sticky: tag pushed while tag FIFO full.
- err_orphan  out  1  sticky: beat received with no pending tag.
- err_data_ovf  out  1  sticky: beat received while data FIFO full.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: both FIFOs empty; all counters 0; all error flags 0. rd_valid=0, rd_last=0, rd_data=0, rd_tag=0, pend_cnt=0. Reset mid-burst discards all queued tags and beats; no partial-burst recovery.
- Tag push:
  - Condition: dly_cmd[35] & dly_cmd[34]; non-read or invalid words are ignored.
  - Tag FIFO full → tag dropped, err_tag_ovf set, pend_cnt not incremented.
- Input side:
  - On phy_rvalid, the beat is written to the data FIFO and the in-beat counter advances 0..BURST_BEATS-1, wrapping to 0.
  - Wrap from BURST_BEATS-1 to 0 decrements pend_cnt.
  - Orphan check: phy_rvalid while pend_cnt==0 and no tag push this cycle → beat dropped, err_orphan set, in-beat counter unchanged.
  - A same-cycle tag push counts as pending.
  - Data FIFO full → beat dropped, err_data_ovf set. The in-beat counter still advances so burst framing is preserved.
- pend_cnt: simultaneous push and last beat in the same cycle leaves it unchanged. Saturates at TAG_DEPTH by construction.
- Output side:
  - First-word fall-through: rd_valid = data FIFO not empty.
  - Latency: phy_rvalid at cycle N → rd_valid at N+1 if the FIFO was empty.
  - rd_tag = tag FIFO head. rd_last = (out-beat counter == BURST_BEATS-1).
  - Transfer occurs on rd_valid & rd_ready. The out-beat counter advances and wraps; on a transferred last beat the tag FIFO pops.
  - rd_data, rd_tag and rd_last are held stable while rd_valid & !rd_ready.
- Simultaneous write and read on either FIFO at occupancy full or empty: a read when non-empty and a write when non-full both occur; occupancy unchanged. At empty, a write plus no read is possible (FWFT shows the beat the next cycle).
- Pointer arithmetic: $clog2(depth)+1 bits, wrap naturally; full = MSBs differ and LSBs equal.
- Error flags clear only on rst.

Optional Feature:
- Macro: DDR3_RD_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYC (default 64) and output err_timeout (1 bit, sticky).
  - A counter counts cycles with pend_cnt>0 and no phy_rvalid; it reloads to 0 on any phy_rvalid or when pend_cnt==0.
  - Reaching TIMEOUT_CYC sets err_timeout. The counter saturates there; there is no other side effect.
- Undefined: no counter, no err_timeout port.

Test Plan:
- Basic burst: dly_cmd valid,read,tag=0x15, then 8 phy_rvalid beats 0x100..0x107, rd_ready=1 → rd_data 0x100..0x107, rd_tag=0x15 on all beats, rd_last only on 0x107, pend_cnt 1→0.
- Back-to-back: tags 0x01 and 0x02 pushed 8 cycles apart, 16 continuous beats → first 8 beats carry tag 0x01 and the second 8 carry tag 0x02; rd_last on beats 8 and 16.
- Backpressure: rd_ready=0 for 20 cycles during two bursts → 16 beats held; rd_valid=1 and outputs stable; on release all 16 beats drain in order with no error flags set.
- Orphan: phy_rvalid with pend_cnt=0 and no push → err_orphan=1, rd_valid stays 0.
- Overflow: 9 read commands pushed with no data → err_tag_ovf=1, pend_cnt=8. Separately, 5 bursts with rd_ready=0 → err_data_ovf=1 and the FIFO holds the first 32 beats.
- Reset mid-burst: rst asserted after 3 of 8 beats → rd_valid=0, pend_cnt=0; a fresh tag plus 8 beats afterwards is returned correctly. With DDR3_RD_TIMEOUT_EN, a tag pushed and no data for 64 cycles → err_timeout=1.
